// File: rtl/fixed_mac_accum_if.sv
// fixed_mac_accum_if
// Purpose : groups the operand-input and result-output handshakes of
//           fixed_mac_accum into one bundle.
// Signals :
//   in_valid / in_ready   - operand pair handshake (a, b, signed Q5.26)
//   out_valid / out_ready - result handshake (q, signed Q5.26; ovf sticky flag)
// Modports:
//   master - the producer/consumer side (drives operands and out_ready)
//   slave  - the MAC block itself
interface fixed_mac_accum_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] q;
  logic        ovf;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, q, ovf
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, q, ovf
  );
endinterface

// File: rtl/fixed_mac_accum.sv
// fixed_mac_accum
// Purpose : sequential fixed-point multiply-accumulate. Accepts N signed
//           Q5.26 operand pairs, forms each product with sign-magnitude
//           multiplication and truncation to bits [FRAC_BITS+31:FRAC_BITS],
//           sums them into a 32-bit accumulator and presents the result on
//           a valid/ready output.
// Ports   :
//   clk   - rising-edge clock
//   reset - asynchronous, active-high reset; aborts any vector in flight
//   bus   - fixed_mac_accum_if.slave (in_valid/in_ready/a/b,
//           out_valid/out_ready/q/ovf)
// Parameters:
//   N         - products per dot product (2..65535)
//   FRAC_BITS - fractional bits of the Q format
// Build option:
//   MAC_SATURATE_EN - when defined, an overflowing add clamps the
//                     accumulator to the signed 32-bit limits instead of
//                     wrapping. ovf is set in either case.
module fixed_mac_accum #(
  parameter int N         = 16,
  parameter int FRAC_BITS = 26
) (
  input logic          clk,
  input logic          reset,
  fixed_mac_accum_if.slave bus
);

  localparam int CW = $clog2(N);

  // IDLE only exists so that in_ready stays low for the remainder of the
  // cycle in which reset is released; it always advances to ACCUM.
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [31:0]   prod_r;
  logic          prod_v;
  logic [31:0]   acc;
  logic          ovf_reg;

  logic [31:0]   mag_a;
  logic [31:0]   mag_b;
  logic [63:0]   prod_full;
  logic [31:0]   prod_slice;
  logic [31:0]   prod_next;
  logic          accept;
  logic          handshake;
  logic [31:0]   sum;
  logic          add_ovf;
  logic [31:0]   acc_add;

  // Product path: 0x80000000 maps to magnitude 2^31, which still fits the
  // 32-bit unsigned magnitude.
  always_comb begin
    mag_a      = bus.a[31] ? ~(bus.a - 32'd1) : bus.a;
    mag_b      = bus.b[31] ? ~(bus.b - 32'd1) : bus.b;
    prod_full  = {32'd0, mag_a} * {32'd0, mag_b};
    prod_slice = 32'(prod_full >> FRAC_BITS);
    prod_next  = (bus.a[31] ^ bus.b[31]) ? (~prod_slice + 32'd1) : prod_slice;
  end

  always_comb begin
    sum     = acc + prod_r;
    add_ovf = (acc[31] == prod_r[31]) && (sum[31] != acc[31]);
`ifdef MAC_SATURATE_EN
    // Operands share a sign on overflow, so acc[31] gives the direction.
    acc_add = add_ovf ? (acc[31] ? 32'h8000_0000 : 32'h7FFF_FFFF) : sum;
`else
    acc_add = sum;
`endif
  end

  assign accept    = bus.in_valid && (state == ACCUM);
  assign handshake = bus.out_ready && (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      prod_r  <= '0;
      prod_v  <= 1'b0;
      acc     <= '0;
      ovf_reg <= 1'b0;
    end else begin
      prod_v <= accept;
      if (accept) begin
        prod_r <= prod_next;
      end

      // prod_v is always low in DONE, so these two branches never collide.
      if (handshake) begin
        acc     <= '0;
        ovf_reg <= 1'b0;
      end else if (prod_v) begin
        acc <= acc_add;
        if (add_ovf) begin
          ovf_reg <= 1'b1;
        end
      end

      case (state)
        IDLE: state <= ACCUM;
        ACCUM: begin
          if (accept) begin
            if (cnt == CW'(N - 1)) begin
              state <= DRAIN;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DRAIN: state <= DONE;
        DONE: begin
          if (bus.out_ready) begin
            state <= ACCUM;
            cnt   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == ACCUM);
  assign bus.out_valid = (state == DONE);
  assign bus.q         = acc;
  assign bus.ovf       = ovf_reg;

endmodule

// File: tb/tb_fixed_mac_accum.sv
// tb_fixed_mac_accum
// Purpose : self-checking bench for fixed_mac_accum (N=4). Directed vectors
//           from the test plan plus randomized vectors, all compared with a
//           behavioural dot-product model using plain integer arithmetic.
// Build option: honours MAC_SATURATE_EN for the expected overflow result.
module tb_fixed_mac_accum;

  localparam int N = 4;

  logic clk = 1'b0;
  logic reset;

  fixed_mac_accum_if bus ();

  fixed_mac_accum #(.N(N), .FRAC_BITS(26)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] va [N];
  logic [31:0] vb [N];
  logic [31:0] last_q;
  logic        last_ovf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One product: |a|*|b| as plain integers, keep 32 bits above the binary
  // point, apply the sign of the result.
  function automatic logic [31:0] model_prod(input logic [31:0] x, input logic [31:0] y);
    longint unsigned mx, my, p;
    logic [31:0] s;
    mx = x[31] ? (64'h1_0000_0000 - {32'd0, x}) : {32'd0, x};
    my = y[31] ? (64'h1_0000_0000 - {32'd0, y}) : {32'd0, y};
    p  = mx * my;
    s  = 32'((p >> 26) & 64'hFFFF_FFFF);
    if (x[31] ^ y[31]) s = -s;
    return s;
  endfunction

  task automatic model_vector(output logic [31:0] q, output logic o);
    longint acc;
    int     t;
    acc = 0;
    o   = 1'b0;
    for (int i = 0; i < N; i++) begin
      t   = int'(model_prod(va[i], vb[i]));
      acc = acc + longint'(t);
      if (acc > 64'sd2147483647 || acc < -64'sd2147483648) begin
        o = 1'b1;
`ifdef MAC_SATURATE_EN
        acc = (acc > 0) ? 64'sd2147483647 : -64'sd2147483648;
`else
        t   = int'(acc);
        acc = longint'(t);
`endif
      end
    end
    q = 32'(acc);
  endtask

  // Called just after a negedge with the block in ACCUM. Returns just after
  // the negedge following the output handshake, again in ACCUM.
  task automatic run_vector(input string tag, input int stall_at, input int stall_len,
                            input bit rand_stall, input int bp);
    logic [31:0] exp_q;
    logic        exp_o;
    int          lat;
    model_vector(exp_q, exp_o);
    for (int i = 0; i < N; i++) begin
      if (i == stall_at) begin
        bus.in_valid = 1'b0;
        repeat (stall_len) @(negedge clk);
      end else if (rand_stall && $urandom_range(0, 3) == 0) begin
        bus.in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      bus.in_valid = 1'b1;
      bus.a = va[i];
      bus.b = vb[i];
      check({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
      @(negedge clk);
    end
    // DRAIN: offer junk that must be ignored, and set up backpressure.
    bus.in_valid  = 1'b1;
    bus.a         = $urandom;
    bus.b         = $urandom;
    bus.out_ready = (bp == 0);
    check({tag, "_drain_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
    lat = 1;
    while (!bus.out_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd2);
    check({tag, "_q"}, bus.q, exp_q);
    check({tag, "_ovf"}, {31'd0, bus.ovf}, {31'd0, exp_o});
    check({tag, "_done_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
    last_q   = bus.q;
    last_ovf = bus.ovf;
    for (int k = 0; k < bp; k++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, {31'd0, bus.out_valid}, 32'd1);
      check({tag, "_hold_q"}, bus.q, exp_q);
      check({tag, "_hold_ovf"}, {31'd0, bus.ovf}, {31'd0, exp_o});
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check({tag, "_post_valid"}, {31'd0, bus.out_valid}, 32'd0);
    check({tag, "_post_ovf"}, {31'd0, bus.ovf}, 32'd0);
    check({tag, "_post_q"}, bus.q, 32'd0);
    check({tag, "_post_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
  endtask

  task automatic fill(input logic [31:0] x, input logic [31:0] y);
    for (int i = 0; i < N; i++) begin
      va[i] = x;
      vb[i] = y;
    end
  endtask

  function automatic logic [31:0] rand_operand(input int mode);
    logic [31:0] r;
    r = $urandom;
    case (mode)
      0: return r;
      1: return {{4{r[31]}}, r[31:4]};
      default: begin
        case ($urandom_range(0, 3))
          0: return 32'h8000_0000;
          1: return 32'h7FFF_FFFF;
          2: return 32'h0000_0000;
          default: return {{6{r[31]}}, r[31:6]};
        endcase
      end
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_q", bus.q, 32'd0);
    check("rst_ovf", {31'd0, bus.ovf}, 32'd0);
    #2 reset = 1'b0;
    @(negedge clk);
    check("rel_in_ready", {31'd0, bus.in_ready}, 32'd1);

    fill(32'h0400_0000, 32'h0800_0000);
    run_vector("basic", -1, 0, 1'b0, 0);
    check("basic_const_q", last_q, 32'h2000_0000);
    check("basic_const_ovf", {31'd0, last_ovf}, 32'd0);

    fill(32'hFA00_0000, 32'h0800_0000);
    run_vector("neg", -1, 0, 1'b0, 0);
    check("neg_const_q", last_q, 32'hD000_0000);

    fill(32'h0C00_0000, 32'h0C00_0000);
    run_vector("ovf", -1, 0, 1'b0, 2);
`ifdef MAC_SATURATE_EN
    check("ovf_const_q", last_q, 32'h7FFF_FFFF);
`else
    check("ovf_const_q", last_q, 32'h9000_0000);
`endif
    check("ovf_const_flag", {31'd0, last_ovf}, 32'd1);

    fill(32'h0400_0000, 32'h0800_0000);
    run_vector("stall", 2, 3, 1'b0, 5);
    check("stall_const_q", last_q, 32'h2000_0000);

    fill(32'h8000_0000, 32'h0040_0000);
    run_vector("mostneg", -1, 0, 1'b0, 1);
    check("mostneg_const_q", last_q, 32'hE000_0000);

    // Abort a vector after two accepted pairs with an asynchronous reset.
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1;
      bus.a = 32'h0400_0000;
      bus.b = 32'h0800_0000;
      @(negedge clk);
    end
    #2 reset = 1'b1;
    #1;
    check("arst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("arst_q", bus.q, 32'd0);
    check("arst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("arst_ovf", {31'd0, bus.ovf}, 32'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2 reset = 1'b0;
    @(negedge clk);
    check("arst_rel_in_ready", {31'd0, bus.in_ready}, 32'd1);
    fill(32'h0400_0000, 32'h0800_0000);
    run_vector("after_rst", -1, 0, 1'b0, 0);
    check("after_rst_const_q", last_q, 32'h2000_0000);

    for (int v = 0; v < 30; v++) begin
      int mode;
      mode = $urandom_range(0, 2);
      for (int i = 0; i < N; i++) begin
        va[i] = rand_operand(mode);
        vb[i] = rand_operand(mode);
      end
      run_vector($sformatf("rand%0d", v), -1, 0, 1'b1, $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
